conv1d_stream_engine: RTL and testbench

- Parametrised 1-D signed fixed-point convolution engine with NUM_LANES parallel MAC lanes.
- Streams an input sequence through a runtime-loadable kernel of up to MAX_TAPS taps.
- Supports "full" mode (zero-padded, len+taps-1 outputs) and "valid" mode (len-taps+1 outputs).
- Successor to the fixed-size matrix convolution block; sits between the sample DMA and the result buffer, with valid/ready streams on both sides.

---
 rtl/conv1d_stream_engine.sv | 202 ++++++++++++++++++++
 tb/tb_conv1d_stream_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D signed convolution engine: runtime kernel, full/valid modes, NUM_LANES MACs per cycle.
// Optional macro CONV_SAT_EN clamps results to the DATA_W range and raises out_sat.
module conv1d_stream_engine #(
  parameter int DATA_W    = 16,
  parameter int MAX_TAPS  = 16,
  parameter int NUM_LANES = 4,
  parameter int LEN_W     = 16,
  parameter int ACC_W     = 2*DATA_W+$clog2(MAX_TAPS)+1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          k_wr_en,
  input  logic [$clog2(MAX_TAPS)-1:0]   k_wr_addr,
  input  logic signed [DATA_W-1:0]      k_wr_data,
  input  logic                          start,
  input  logic [$clog2(MAX_TAPS):0]     cfg_taps,
  input  logic [LEN_W-1:0]              cfg_len,
  input  logic                          cfg_full,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       out_data,
  output logic                          out_sat,
  output logic                          busy,
  output logic                          done
);
  localparam int AW = $clog2(MAX_TAPS);
  localparam int TW = AW + 1;
  localparam int IW = TW + 1;
  localparam int PW = 2 * DATA_W;
  localparam int CW = LEN_W + TW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT, S_FLUSH, S_FIN} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0] h   [MAX_TAPS];
  logic signed [DATA_W-1:0] win [MAX_TAPS];

  logic [TW-1:0]           taps_reg, mac_last, mac_cnt, flush_rem, taps_clamped;
  logic [LEN_W-1:0]        len_reg, cnt, cnt_inc;
  logic                    full_reg;
  logic signed [ACC_W-1:0] acc, lane_sum;
  logic                    shift_in, shift_zero, emit_now;
  logic [IW-1:0]           base;
  logic signed [PW-1:0]    prod [NUM_LANES];

  always_comb begin
    if (cfg_taps == '0)
      taps_clamped = TW'(1);
    else if (cfg_taps > TW'(MAX_TAPS))
      taps_clamped = TW'(MAX_TAPS);
    else
      taps_clamped = cfg_taps;
  end

  assign cnt_inc  = cnt + LEN_W'(1);
  assign emit_now = full_reg || (CW'(cnt_inc) >= CW'(taps_reg));
  assign base     = IW'(mac_cnt) * IW'(NUM_LANES);

  // Lane gi handles tap index base+gi; taps beyond the configured count contribute zero.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [IW-1:0]        k;
      logic [AW-1:0]        ka;
      logic signed [PW-1:0] mul;
      assign k   = base + IW'(gi);
      assign ka  = k[AW-1:0];
      assign mul = win[ka] * h[ka];
      assign prod[gi] = (k < IW'(taps_reg)) ? mul : {PW{1'b0}};
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < NUM_LANES; j++)
      lane_sum = lane_sum + {{(ACC_W-PW){prod[j][PW-1]}}, prod[j]};
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    shift_in   = 1'b0;
    shift_zero = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_next = (cfg_len == '0) ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_in = 1'b1;
          if (emit_now)
            state_next = S_MAC;
          else if (cnt_inc == len_reg)
            state_next = S_FIN;
        end
      end
      S_FLUSH: begin
        shift_zero = 1'b1;
        state_next = S_MAC;
      end
      S_MAC: begin
        if (mac_cnt == mac_last)
          state_next = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt != len_reg)
            state_next = S_LOAD;
          else if (flush_rem != '0)
            state_next = S_FLUSH;
          else
            state_next = S_FIN;
        end
      end
      S_FIN: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      taps_reg  <= '0;
      mac_last  <= '0;
      mac_cnt   <= '0;
      flush_rem <= '0;
      len_reg   <= '0;
      cnt       <= '0;
      full_reg  <= 1'b0;
      acc       <= '0;
      for (int i = 0; i < MAX_TAPS; i++) begin
        h[i]   <= '0;
        win[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (state == S_IDLE && k_wr_en && ({1'b0, k_wr_addr} < TW'(MAX_TAPS)))
        h[k_wr_addr] <= k_wr_data;
      if (state == S_IDLE && start) begin
        taps_reg  <= taps_clamped;
        len_reg   <= cfg_len;
        full_reg  <= cfg_full;
        cnt       <= '0;
        mac_last  <= TW'((taps_clamped - TW'(1)) / TW'(NUM_LANES));
        flush_rem <= cfg_full ? (taps_clamped - TW'(1)) : '0;
        for (int i = 0; i < MAX_TAPS; i++)
          win[i] <= '0;
      end
      // Newest sample lives in win[0]; flush shifts push zeros behind the last sample.
      if (shift_in || shift_zero) begin
        for (int i = MAX_TAPS-1; i > 0; i--)
          win[i] <= win[i-1];
        win[0] <= shift_in ? in_data : '0;
      end
      if (shift_in)
        cnt <= cnt_inc;
      if (shift_zero)
        flush_rem <= flush_rem - TW'(1);
      if ((shift_in && emit_now) || shift_zero) begin
        acc     <= '0;
        mac_cnt <= '0;
      end else if (state == S_MAC) begin
        acc     <= acc + lane_sum;
        mac_cnt <= mac_cnt + TW'(1);
      end
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  always_comb begin
    out_data = acc;
    out_sat  = 1'b0;
    if (acc > SAT_MAX) begin
      out_data = SAT_MAX;
      out_sat  = (state == S_EMIT);
    end else if (acc < SAT_MIN) begin
      out_data = SAT_MIN;
      out_sat  = (state == S_EMIT);
    end
  end
`else
  assign out_data = acc;
  assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Directed bench for conv1d_stream_engine: full/valid modes, latency, backpressure, saturation, mid-job reset.
// Expected results are hand-computed convolutions; CONV_SAT_EN selects the saturation expectation.
module tb_conv1d_stream_engine;
  localparam int DATA_W    = 8;
  localparam int MAX_TAPS  = 16;
  localparam int NUM_LANES = 4;
  localparam int LEN_W     = 16;
  localparam int AW        = $clog2(MAX_TAPS);
  localparam int TW        = AW + 1;
  localparam int ACC_W     = 2*DATA_W + AW + 1;

  logic                     clk;
  logic                     reset;
  logic                     k_wr_en;
  logic [AW-1:0]            k_wr_addr;
  logic signed [DATA_W-1:0] k_wr_data;
  logic                     start;
  logic [TW-1:0]            cfg_taps;
  logic [LEN_W-1:0]         cfg_len;
  logic                     cfg_full;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_sat;
  logic                     busy;
  logic                     done;

  conv1d_stream_engine #(
    .DATA_W(DATA_W), .MAX_TAPS(MAX_TAPS), .NUM_LANES(NUM_LANES), .LEN_W(LEN_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset),
    .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
    .start(start), .cfg_taps(cfg_taps), .cfg_len(cfg_len), .cfg_full(cfg_full),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_kernel(input int coef[$]);
    foreach (coef[i]) begin
      @(negedge clk);
      k_wr_en   = 1'b1;
      k_wr_addr = AW'(i);
      k_wr_data = DATA_W'(coef[i]);
    end
    @(negedge clk);
    k_wr_en = 1'b0;
  endtask

  task automatic run_job(input string name, input bit full, input int taps, input int xs[$],
                         input int ys[$], input int sat_exp, input int lat_exp,
                         input int stall_idx, input bit busy_write);
    int  sent, got, hold, acc_cyc;
    bit  lat_done, stalled, seen_done;
    sent = 0; got = 0; hold = 0; acc_cyc = -1;
    lat_done = 0; stalled = 0; seen_done = 0;
    @(negedge clk);
    cfg_taps = TW'(taps);
    cfg_len  = LEN_W'(xs.size());
    cfg_full = full;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2000 && !seen_done; t++) begin
      k_wr_en = 1'b0;
      if (busy_write && t == 2) begin
        k_wr_en   = 1'b1;
        k_wr_addr = '0;
        k_wr_data = DATA_W'(50);
      end
      in_valid = (sent < xs.size());
      in_data  = in_valid ? DATA_W'(xs[sent]) : '0;
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        sent++;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (lat_exp > 0 && !lat_done && acc_cyc >= 0) begin
          check_val($sformatf("%s latency", name), cyc - acc_cyc, lat_exp);
          lat_done = 1;
        end
        if (got < ys.size()) begin
          check_val($sformatf("%s y[%0d]", name, got), out_data, ys[got]);
          check_val($sformatf("%s sat[%0d]", name, got), out_sat, sat_exp);
          if (got == stall_idx && !stalled) begin
            hold = 10;
            stalled = 1;
          end
          if (hold > 0) begin
            out_ready = 1'b0;
            check_val($sformatf("%s in_ready while stalled", name), in_ready, 0);
            hold--;
          end else begin
            got++;
          end
        end else begin
          check_val($sformatf("%s extra output", name), out_valid, 0);
        end
      end
      if (done) begin
        check_val($sformatf("%s busy at done", name), busy, 0);
        seen_done = 1;
      end
      @(negedge clk);
    end
    k_wr_en  = 1'b0;
    in_valid = 1'b0;
    check_val($sformatf("%s output count", name), got, ys.size());
    check_val($sformatf("%s done seen", name), seen_done, 1);
    check_val($sformatf("%s done single pulse", name), done, 0);
    check_val($sformatf("%s busy after", name), busy, 0);
    $display("job %s: %0d outputs, %0d samples", name, got, sent);
  endtask

  int hq[$];
  int xq[$];
  int yq[$];
  int dsnap;

  initial begin
    reset = 1'b0; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
    start = 1'b0; cfg_taps = '0; cfg_len = '0; cfg_full = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset out_valid", out_valid, 0);
    check_val("reset in_ready", in_ready, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset out_data", out_data, 0);
    reset = 1'b1;
    @(negedge clk);

    hq = '{1, 2, 3};
    load_kernel(hq);
    xq = '{1, 1, 1, 1};
    yq = '{1, 3, 6, 6, 5, 3};
    run_job("full_ones", 1'b1, 3, xq, yq, 0, 0, -1, 1'b1);

    yq = '{6, 6};
    run_job("valid_ones", 1'b0, 3, xq, yq, 0, 0, -1, 1'b0);

    xq = '{1, 1};
    yq = {};
    run_job("valid_short", 1'b0, 3, xq, yq, 0, 0, -1, 1'b0);

    xq = '{1, 2, 3, 4};
    yq = '{1, 4, 10, 16, 17, 12};
    run_job("backpressure", 1'b1, 3, xq, yq, 0, 0, 2, 1'b0);

    hq = '{1, 2, 3, 4, 5, 6, 7};
    load_kernel(hq);
    xq = '{1};
    yq = '{1, 2, 3, 4, 5, 6, 7};
    run_job("taps7", 1'b1, 7, xq, yq, 0, 3, -1, 1'b0);

    hq = '{100, 100};
    load_kernel(hq);
    xq = '{100, 100};
`ifdef CONV_SAT_EN
    yq = '{127};
    run_job("sat", 1'b0, 2, xq, yq, 1, 0, -1, 1'b0);
`else
    yq = '{20000};
    run_job("sat", 1'b0, 2, xq, yq, 0, 0, -1, 1'b0);
`endif

    hq = '{1, 2, 3, 4, 5, 6, 7};
    load_kernel(hq);
    @(negedge clk);
    cfg_taps = TW'(7); cfg_len = LEN_W'(2); cfg_full = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = DATA_W'(1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("midjob in_ready in MAC", in_ready, 0);
    check_val("midjob partial acc", out_data, 1);
    dsnap = done_cnt;
    reset = 1'b0;
    #1;
    check_val("abort out_valid", out_valid, 0);
    check_val("abort busy", busy, 0);
    check_val("abort done", done, 0);
    check_val("abort out_data", out_data, 0);
    check_val("abort out_sat", out_sat, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_val("abort no done pulse", done_cnt, dsnap);

    xq = '{5};
    yq = '{0};
    run_job("cleared_kernel", 1'b0, 1, xq, yq, 0, 0, -1, 1'b0);

    hq = '{1, 2, 3};
    load_kernel(hq);
    xq = '{2, -1, 3};
    yq = '{2, 3, 7, 3, 9};
    run_job("after_reset", 1'b1, 3, xq, yq, 0, 0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
